// File: rtl/cpu_types_pkg.sv
// Shared CPU types: register indices, hazard-controller states and the
// per-stage enable/flush pair used to hook up pipeline registers uniformly.
package cpu_types_pkg;

    localparam int REGBITS_W = 5;

    typedef logic [REGBITS_W-1:0] regbits_t;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MEMWAIT = 2'd1,
        HALTED  = 2'd2
    } hz_state_t;

    typedef struct packed {
        logic en;
        logic flush;
    } stage_ctrl_t;

    // Common stage control encodings
    localparam stage_ctrl_t STG_HOLD   = '{en: 1'b0, flush: 1'b0};
    localparam stage_ctrl_t STG_ADV    = '{en: 1'b1, flush: 1'b0};
    localparam stage_ctrl_t STG_BUBBLE = '{en: 1'b1, flush: 1'b1};
    localparam stage_ctrl_t STG_RESET  = '{en: 1'b0, flush: 1'b1};

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard compare: the load in EX writes a register that the
// instruction in ID reads. Register 0 never creates a dependency.
module hazard_detect #(
    parameter int REG_W = 5
) (
    input  logic             i_ex_memread,
    input  logic [REG_W-1:0] i_ex_rt,
    input  logic [REG_W-1:0] i_id_rs,
    input  logic [REG_W-1:0] i_id_rt,
    input  logic             i_id_uses_rt,
    output logic             o_lu_stall
);

    logic w_rs_match;
    logic w_rt_match;

    assign w_rs_match = (i_ex_rt == i_id_rs);
    assign w_rt_match = i_id_uses_rt & (i_ex_rt == i_id_rt);
    assign o_lu_stall = i_ex_memread & (i_ex_rt != '0) & (w_rs_match | w_rt_match);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central hazard sequencer for the 5-stage pipeline: stage enables/flushes,
// PC enable, gated data-cache requests, sticky halt and a stall counter.
module pipeline_hazard_ctrl
    import cpu_types_pkg::*;
#(
    parameter int CNT_W = 32,
    parameter int REG_W = 5
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             iHit,
    input  logic             dHit,
    input  logic             m_dREN,
    input  logic             m_dWEN,
    input  logic             ex_memread,
    input  logic [REG_W-1:0] ex_rt,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_branch_taken,
    input  logic             id_jump,
    input  logic             wb_halt,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_en,
    output logic             idex_flush,
    output logic             exm_en,
    output logic             exm_flush,
    output logic             mwb_en,
    output logic             mwb_flush,
    output logic             dREN_gated,
    output logic             dWEN_gated,
    output logic             halt,
    output logic [CNT_W-1:0] stall_cnt
);

    hz_state_t        r_state;
    hz_state_t        w_state_nxt;
    logic             r_dmem_done;
    logic [CNT_W-1:0] r_stall_cnt;

    logic             w_memreq;
    logic             w_lu_stall;
    logic             w_pc_en;
    stage_ctrl_t      w_ifid;
    stage_ctrl_t      w_idex;
    stage_ctrl_t      w_exm;
    stage_ctrl_t      w_mwb;

    // An access already satisfied while EX_M was held must not go out again.
    assign w_memreq = (m_dREN | m_dWEN) & ~r_dmem_done;

    hazard_detect #(
        .REG_W(REG_W)
    ) u_hazard_detect (
        .i_ex_memread(ex_memread),
        .i_ex_rt     (ex_rt),
        .i_id_rs     (id_rs),
        .i_id_rt     (id_rt),
        .i_id_uses_rt(id_uses_rt),
        .o_lu_stall  (w_lu_stall)
    );

    // Prioritised stage control; the default freezes every stage.
    always_comb begin
        w_pc_en = 1'b0;
        w_ifid  = STG_HOLD;
        w_idex  = STG_HOLD;
        w_exm   = STG_HOLD;
        w_mwb   = STG_HOLD;
        if (RST) begin
            w_ifid = STG_RESET;
            w_idex = STG_RESET;
            w_exm  = STG_RESET;
            w_mwb  = STG_RESET;
        end else if (r_state == HALTED) begin
            w_pc_en = 1'b0;
        end else if (w_memreq & ~dHit) begin
            w_pc_en = 1'b0;
        end else if (~iHit) begin
            if (w_memreq) begin
                // Data access completes this cycle but EX_M holds; everything
                // upstream must hold too or the ID_EX instruction would be lost.
                w_pc_en = 1'b0;
            end else if (w_lu_stall) begin
                w_idex = STG_BUBBLE;
                w_exm  = STG_ADV;
                w_mwb  = STG_ADV;
            end else begin
                w_ifid = STG_BUBBLE;
                w_idex = STG_ADV;
                w_exm  = STG_ADV;
                w_mwb  = STG_ADV;
            end
        end else if (ex_branch_taken) begin
            w_pc_en = 1'b1;
            w_ifid  = STG_BUBBLE;
            w_idex  = STG_BUBBLE;
            w_exm   = STG_ADV;
            w_mwb   = STG_ADV;
        end else if (w_lu_stall) begin
            w_idex = STG_BUBBLE;
            w_exm  = STG_ADV;
            w_mwb  = STG_ADV;
        end else if (id_jump) begin
            w_pc_en = 1'b1;
            w_ifid  = STG_BUBBLE;
            w_idex  = STG_ADV;
            w_exm   = STG_ADV;
            w_mwb   = STG_ADV;
        end else begin
            w_pc_en = 1'b1;
            w_ifid  = STG_ADV;
            w_idex  = STG_ADV;
            w_exm   = STG_ADV;
            w_mwb   = STG_ADV;
        end
    end

    // Next-state logic: halt is accepted only when M_WB actually advances.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            RUN: begin
                if (wb_halt & w_mwb.en)
                    w_state_nxt = HALTED;
                else if (w_memreq & ~dHit)
                    w_state_nxt = MEMWAIT;
            end
            MEMWAIT: begin
                if (wb_halt & w_mwb.en)
                    w_state_nxt = HALTED;
                else if (dHit)
                    w_state_nxt = RUN;
            end
            HALTED:  w_state_nxt = HALTED;
            default: w_state_nxt = RUN;
        endcase
    end

    // State register; reset abandons any outstanding data access.
    always_ff @(posedge CLK) begin
        if (RST)
            r_state <= RUN;
        else
            r_state <= w_state_nxt;
    end

    // Remember a data access that finished while EX_M could not advance.
    always_ff @(posedge CLK) begin
        if (RST)
            r_dmem_done <= 1'b0;
        else if (w_exm.en)
            r_dmem_done <= 1'b0;
        else if (w_memreq & dHit & ~iHit & (r_state != HALTED))
            r_dmem_done <= 1'b1;
    end

    // Saturating count of cycles in which the PC did not advance.
    always_ff @(posedge CLK) begin
        if (RST)
            r_stall_cnt <= '0;
        else if (~w_pc_en & (r_state != HALTED) & (r_stall_cnt != '1))
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end

    assign halt       = (r_state == HALTED);
    assign dREN_gated = m_dREN & ~r_dmem_done & ~halt & ~RST;
    assign dWEN_gated = m_dWEN & ~r_dmem_done & ~halt & ~RST;

    assign pc_en      = w_pc_en;
    assign ifid_en    = w_ifid.en;
    assign ifid_flush = w_ifid.flush;
    assign idex_en    = w_idex.en;
    assign idex_flush = w_idex.flush;
    assign exm_en     = w_exm.en;
    assign exm_flush  = w_exm.flush;
    assign mwb_en     = w_mwb.en;
    assign mwb_flush  = w_mwb.flush;
    assign stall_cnt  = r_stall_cnt;

endmodule
